jk_excitation_driver: RTL and testbench

//  Drives a bank of WIDTH jk_flipflop instances toward a requested target word and checks the result.
//  - Accepts a target word over a valid/ready handshake.
//  - Computes J/K excitation from the target and the current q, pulses it for one clock, then reads q back.
//  - Reports done/match per transaction and keeps a saturating mismatch count.
//  - Drive-side counterpart to the JK flop: self-checking stimulus engine in flop-level benches, and the JK sequencer in small counters.

---
 rtl/jk_drv_pkg.sv | 13 +
 rtl/jk_excitation_enc.sv | 24 ++
 rtl/jk_excitation_driver.sv | 85 ++++++++
 tb/tb_jk_excitation_driver.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK excitation driver and its encoder.
package jk_drv_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam int EXC_SR  = 0;
  localparam int EXC_MIN = 1;

endpackage

// File: rtl/jk_excitation_enc.sv
// Combinational JK excitation: derives per-bit J/K that move q to t on the next edge.
module jk_excitation_enc
  import jk_drv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  // Neither form ever asserts J and K together, so no bit is ever toggled.
  always_comb begin
    j = t;
    k = ~t;
    if (mode == 1'(EXC_MIN)) begin
      j = t & ~q;
      k = ~t & q;
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a bank of JK flops to a requested target word, then checks the readback.
module jk_excitation_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int EXC_MODE = 0,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q,
  output logic             done,
  output logic             match,
  output logic [ERR_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam logic MODE_BIT = (EXC_MODE == EXC_MIN);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] j_enc;
  logic [WIDTH-1:0] k_enc;
  logic             accept;
  logic             in_check;
  logic             is_match;

  assign tgt_ready = (state == S_IDLE);
  assign accept    = tgt_valid & tgt_ready;
  assign in_check  = (state == S_CHECK);
  assign is_match  = (q == tgt_r);

  // Excitation is formed from the incoming word and q as seen at the accept edge.
  jk_excitation_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .t   (tgt_data),
    .q   (q),
    .mode(MODE_BIT),
    .j   (j_enc),
    .k   (k_enc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_DRIVE;
      S_DRIVE: state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // j/k are loaded only on accept, so they are live for the DRIVE cycle alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tgt_r   <= '0;
      j       <= '0;
      k       <= '0;
      done    <= 1'b0;
      match   <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_nxt;
      done  <= in_check;
      j     <= accept ? j_enc : '0;
      k     <= accept ? k_enc : '0;
      if (accept) tgt_r <= tgt_data;
      if (in_check) match <= is_match;
      if (err_clr) begin
        err_cnt <= '0;
      end else if (in_check && !is_match && (err_cnt != {ERR_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench: two drivers (set/reset form, ERR_W=8; minimal form, ERR_W=2) each on its own JK bank.
module tb_jk_excitation_driver;

  localparam int MAX_A = 255;
  localparam int MAX_B = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgt_valid = 1'b0;
  logic [3:0] tgt_data = '0;
  logic       err_clr = 1'b0;
  logic       freeze = 1'b0;

  logic       ready_a, ready_b, done_a, done_b, match_a, match_b;
  logic [3:0] j_a, k_a, q_a, j_b, k_b, q_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  int nchk = 0;
  int nerr = 0;

  // Reference state: expected bank contents and mismatch tallies.
  logic [3:0] mq_a, mq_b;
  int         me_a, me_b;

  always #5 clk = ~clk;

  jk_excitation_driver #(.WIDTH(4), .EXC_MODE(0), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(ready_a),
    .j(j_a), .k(k_a), .q(q_a), .done(done_a), .match(match_a), .err_cnt(err_a), .err_clr(err_clr)
  );

  jk_excitation_driver #(.WIDTH(4), .EXC_MODE(1), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(ready_b),
    .j(j_b), .k(k_b), .q(q_b), .done(done_b), .match(match_b), .err_cnt(err_b), .err_clr(err_clr)
  );

  // JK flop banks; freeze makes them ignore j/k to provoke mismatches.
  always @(posedge clk) begin
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else if (!freeze) begin
      q_a <= (j_a & ~q_a) | (~k_a & q_a);
      q_b <= (j_b & ~q_b) | (~k_b & q_b);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tgt_valid = 1'b0;
    err_clr = 1'b0;
    freeze = 1'b0;
    tgt_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq_a = '0;
    mq_b = '0;
    me_a = 0;
    me_b = 0;
  endtask

  task automatic do_txn(input logic [3:0] t, input bit frz, input bit clr, input string tag);
    logic [3:0] xj_a, xk_a, xj_b, xk_b, chg;
    logic       xm_a, xm_b;
    int         w;
    w = 0;
    while (!(ready_a && ready_b) && w < 10) begin
      @(negedge clk);
      w++;
    end
    nchk++;
    if ({ready_a, ready_b} !== 2'b11) begin
      nerr++;
      $display("[TB] FAIL %s_idle_ready got %b%b want 11", tag, ready_a, ready_b);
    end
    xj_a = t;
    xk_a = ~t;
    chg  = t ^ mq_b;
    xj_b = chg & t;
    xk_b = chg & mq_b;
    tgt_valid = 1'b1;
    tgt_data = t;
    freeze = frz;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    tgt_data = 4'($urandom);
    nchk++;
    if ({ready_a, ready_b, done_a, done_b} !== 4'b0000) begin
      nerr++;
      $display("[TB] FAIL %s_drive_ctrl got rdy=%b%b done=%b%b want 00/00", tag, ready_a, ready_b, done_a, done_b);
    end
    nchk++;
    if ({j_a, k_a} !== {xj_a, xk_a}) begin
      nerr++;
      $display("[TB] FAIL %s_drive_jk_a got j=%b k=%b want j=%b k=%b", tag, j_a, k_a, xj_a, xk_a);
    end
    nchk++;
    if ({j_b, k_b} !== {xj_b, xk_b}) begin
      nerr++;
      $display("[TB] FAIL %s_drive_jk_b got j=%b k=%b want j=%b k=%b", tag, j_b, k_b, xj_b, xk_b);
    end
    if (!frz) begin
      mq_a = t;
      mq_b = t;
    end
    @(posedge clk);
    @(negedge clk);
    nchk++;
    if ({j_a, k_a, j_b, k_b} !== 16'h0000) begin
      nerr++;
      $display("[TB] FAIL %s_check_jk_idle got %h want 0000", tag, {j_a, k_a, j_b, k_b});
    end
    nchk++;
    if ({q_a, q_b} !== {mq_a, mq_b}) begin
      nerr++;
      $display("[TB] FAIL %s_bank_q got %b/%b want %b/%b", tag, q_a, q_b, mq_a, mq_b);
    end
    err_clr = clr;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    freeze = 1'b0;
    xm_a = (mq_a == t);
    xm_b = (mq_b == t);
    if (clr) me_a = 0; else if (!xm_a && me_a < MAX_A) me_a++;
    if (clr) me_b = 0; else if (!xm_b && me_b < MAX_B) me_b++;
    nchk++;
    if ({done_a, done_b, ready_a, ready_b} !== 4'b1111) begin
      nerr++;
      $display("[TB] FAIL %s_done got done=%b%b rdy=%b%b want 11/11", tag, done_a, done_b, ready_a, ready_b);
    end
    nchk++;
    if ({match_a, match_b} !== {xm_a, xm_b}) begin
      nerr++;
      $display("[TB] FAIL %s_match got %b%b want %b%b", tag, match_a, match_b, xm_a, xm_b);
    end
    nchk++;
    if (err_a !== 8'(me_a) || err_b !== 2'(me_b)) begin
      nerr++;
      $display("[TB] FAIL %s_err_cnt got %0d/%0d want %0d/%0d", tag, err_a, err_b, me_a, me_b);
    end
    @(posedge clk);
    @(negedge clk);
    nchk++;
    if ({done_a, done_b} !== 2'b00) begin
      nerr++;
      $display("[TB] FAIL %s_done_pulse got %b%b want 00", tag, done_a, done_b);
    end
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if ({ready_a, ready_b, done_a, done_b, match_a, match_b} !== 6'b110000) begin
      nerr++;
      $display("[TB] FAIL reset_ctrl got %b want 110000", {ready_a, ready_b, done_a, done_b, match_a, match_b});
    end
    nchk++;
    if ({j_a, k_a, j_b, k_b} !== 16'h0000) begin
      nerr++;
      $display("[TB] FAIL reset_jk got %h want 0000", {j_a, k_a, j_b, k_b});
    end
    nchk++;
    if ({err_a, err_b} !== 10'd0) begin
      nerr++;
      $display("[TB] FAIL reset_err got %0d/%0d want 0/0", err_a, err_b);
    end
  endtask

  task automatic test_basic();
    do_txn(4'b1010, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_min_mode();
    do_txn(4'b0110, 1'b0, 1'b0, "min_change");
    do_txn(4'b0110, 1'b0, 1'b0, "min_same");
  endtask

  task automatic test_mismatch();
    do_reset();
    for (int i = 0; i < 4; i++) do_txn(4'b1111, 1'b1, 1'b0, "mismatch");
  endtask

  task automatic test_back_to_back();
    logic [3:0] list [3];
    int         acc [3];
    int         idx, nd;
    list[0] = 4'b1100;
    list[1] = 4'b0011;
    list[2] = 4'b1001;
    idx = 1;
    nd = 0;
    acc[0] = 0;
    acc[1] = -100;
    acc[2] = -100;
    tgt_valid = 1'b1;
    tgt_data = list[0];
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a || done_b) begin
        nchk++;
        if (nd >= 3 || cyc != acc[nd] + 3 || {done_a, done_b, match_a, match_b} !== 4'b1111) begin
          nerr++;
          $display("[TB] FAIL b2b_done cyc=%0d got done=%b%b match=%b%b want done 3 cycles after accept with match",
                   cyc, done_a, done_b, match_a, match_b);
        end
        nd++;
      end
      if (idx < 3) begin
        if (ready_a && ready_b) begin
          tgt_data = list[idx];
          acc[idx] = cyc;
          idx++;
        end
      end else begin
        tgt_valid = 1'b0;
      end
    end
    tgt_valid = 1'b0;
    nchk++;
    if (nd != 3 || acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
      nerr++;
      $display("[TB] FAIL b2b_spacing got dones=%0d accepts=%0d,%0d,%0d want 3 dones at 0,3,6",
               nd, acc[0], acc[1], acc[2]);
    end
    nchk++;
    if ({q_a, q_b} !== 8'b1001_1001) begin
      nerr++;
      $display("[TB] FAIL b2b_final_q got %b/%b want 1001/1001", q_a, q_b);
    end
    mq_a = 4'b1001;
    mq_b = 4'b1001;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    tgt_valid = 1'b1;
    tgt_data = 4'b0111;
    @(posedge clk);
    @(negedge clk);
    tgt_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq_a = '0;
    mq_b = '0;
    me_a = 0;
    me_b = 0;
    nchk++;
    if ({j_a, k_a, j_b, k_b} !== 16'h0000) begin
      nerr++;
      $display("[TB] FAIL rst_mid_jk got %h want 0000", {j_a, k_a, j_b, k_b});
    end
    nchk++;
    if ({ready_a, ready_b, err_a, err_b} !== {2'b11, 10'd0}) begin
      nerr++;
      $display("[TB] FAIL rst_mid_state got rdy=%b%b err=%0d/%0d want 11 0/0", ready_a, ready_b, err_a, err_b);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done_a || done_b) saw_done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    nchk++;
    if (saw_done) begin
      nerr++;
      $display("[TB] FAIL rst_mid_no_done got done pulse want none");
    end
    do_txn(4'b0101, 1'b0, 1'b0, "post_rst");
  endtask

  task automatic test_err_clr();
    do_txn(4'b1111, 1'b1, 1'b0, "clr_pre");
    do_txn(4'b1111, 1'b1, 1'b1, "clr_hit");
    nchk++;
    if ({err_a, err_b} !== 10'd0) begin
      nerr++;
      $display("[TB] FAIL clr_priority got %0d/%0d want 0/0", err_a, err_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_txn(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), "rand");
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_min_mode();
    test_mismatch();
    test_back_to_back();
    test_reset_mid();
    test_err_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
